// File: rtl/wdg_pkg.sv
// Shared definitions for the APB4 watchdog.
// Contents: register byte offsets and the decoded word-select enum, the unlock
// key, the prescaler width, CTRL bit positions, the CMP reset value and the
// state type of the key/lock machine.
// No ports (package).
package wdg_pkg;

    localparam logic [4:0] OFF_CTRL = 5'h00;
    localparam logic [4:0] OFF_PSCR = 5'h04;
    localparam logic [4:0] OFF_CNT  = 5'h08;
    localparam logic [4:0] OFF_CMP  = 5'h0C;
    localparam logic [4:0] OFF_STAT = 5'h10;
    localparam logic [4:0] OFF_KEY  = 5'h14;
    localparam logic [4:0] OFF_FEED = 5'h18;

    localparam logic [31:0] WDG_KEY     = 32'h5F37_59DF;
    localparam int unsigned PSC_W       = 20;
    localparam logic [31:0] CMP_RST_VAL = 32'hFFFF_FFFF;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_IRQEN = 1;
    localparam int unsigned CTRL_RSTEN = 2;

    // Word select taken from paddr[4:2]; the encodings follow the byte offsets.
    typedef enum logic [2:0] {
        REG_CTRL = OFF_CTRL[4:2],
        REG_PSCR = OFF_PSCR[4:2],
        REG_CNT  = OFF_CNT[4:2],
        REG_CMP  = OFF_CMP[4:2],
        REG_STAT = OFF_STAT[4:2],
        REG_KEY  = OFF_KEY[4:2],
        REG_FEED = OFF_FEED[4:2],
        REG_RSVD = 3'd7
    } reg_sel_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    function automatic logic is_protected(input reg_sel_e sel);
        return (sel == REG_CTRL) || (sel == REG_PSCR) ||
               (sel == REG_CMP)  || (sel == REG_FEED);
    endfunction

endpackage

// File: rtl/apb4_watchdog_if.sv
// APB4 completer-side bus bundle for the watchdog.
// Signals keep the peripheral's port names: paddr_i, pprot_i, psel_i,
// penable_i, pwrite_i, pwdata_i, pstrb_i (requester-driven) and pready_o,
// prdata_o, pslverr_o (watchdog-driven).
// Modports: master (bus requester / testbench), slave (watchdog).
interface apb4_watchdog_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr_i;
    logic [2:0]              pprot_i;
    logic                    psel_i;
    logic                    penable_i;
    logic                    pwrite_i;
    logic [DATA_WIDTH-1:0]   pwdata_i;
    logic [DATA_WIDTH/8-1:0] pstrb_i;
    logic                    pready_o;
    logic [DATA_WIDTH-1:0]   prdata_o;
    logic                    pslverr_o;

    modport master (
        output paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/wdg_prescaler.sv
// Watchdog prescaler: pcnt counts enabled cycles and wraps at pscr_i,
// producing a one-cycle tick on the wrap.
// Ports: clk_i, rst_i (async, active-high), en_i (count enable),
// pscr_i (prescale value), clr_i (clear pcnt), tick_o (one-cycle tick).
module wdg_prescaler
    import wdg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [PSC_W-1:0] pscr_i,
    input  logic             clr_i,
    output logic             tick_o
);
    logic [PSC_W-1:0] pcnt_q;
    logic             hit;

    assign hit = (pcnt_q == pscr_i);
    // A clear restarts the period, so it also suppresses a coincident tick.
    assign tick_o = en_i & hit & ~clr_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
        end else if (clr_i) begin
            pcnt_q <= '0;
        end else if (en_i) begin
            pcnt_q <= hit ? '0 : pcnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/apb4_watchdog.sv
// APB4 watchdog timer: prescaled up-counter compared against a software limit.
// On overflow it sets OVIF, raises irq_o when IRQEN=1 and pulses rst_o for one
// cycle when RSTEN=1. FEED writes restart the count.
// Ports: clk_i, rst_i (async, active-high), apb (apb4_watchdog_if.slave),
// irq_o (level interrupt), rst_o (registered one-cycle reset request).
// Build option: WDG_KEY_LOCK_EN enables the KEY register and the LOCK bit that
// guards CTRL/PSCR/CMP/FEED writes; without it those registers are always
// writable, KEY is ignored and LOCK reads 0.
module apb4_watchdog
    import wdg_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    apb4_watchdog_if.slave  apb,
    output logic            irq_o,
    output logic            rst_o
);
    reg_sel_e         sel;
    logic             access;
    logic             err;
    logic             wr_ok;
    logic             locked;
    logic             feed;
    logic             tick;
    logic             ovf;
    logic [2:0]       ctrl_q;
    logic [PSC_W-1:0] pscr_q;
    logic [31:0]      cmp_q;
    logic [31:0]      cnt_q;
    logic             ovif_q;
    logic             rst_q;
    logic             unused_ok;

    assign unused_ok = ^{apb.pprot_i, apb.pstrb_i, apb.paddr_i};

    assign sel    = reg_sel_e'(apb.paddr_i[4:2]);
    assign access = apb.psel_i & apb.penable_i;
    assign err    = access & ((sel == REG_RSVD) ||
                              (apb.pwrite_i && sel == REG_CNT) ||
                              (apb.pwrite_i && is_protected(sel) && locked));
    assign wr_ok  = access & apb.pwrite_i & ~err;
    assign feed   = wr_ok & (sel == REG_FEED);

`ifdef WDG_KEY_LOCK_EN
    lock_e lock_q;
    lock_e lock_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lock_q <= LOCKED;
        else       lock_q <= lock_d;
    end

    // One unlock buys exactly one protected write.
    always_comb begin
        lock_d = lock_q;
        if (wr_ok && sel == REG_KEY)
            lock_d = (apb.pwdata_i == WDG_KEY) ? UNLOCKED : LOCKED;
        else if (wr_ok && is_protected(sel))
            lock_d = LOCKED;
    end

    assign locked = (lock_q == LOCKED);
`else
    assign locked = 1'b0;
`endif

    wdg_prescaler u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (ctrl_q[CTRL_EN]),
        .pscr_i (pscr_q),
        .clr_i  (feed | (wr_ok && sel == REG_PSCR)),
        .tick_o (tick)
    );

    // FEED has priority over an overflow landing on the same edge.
    assign ovf = tick & (cnt_q == cmp_q) & ~feed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            pscr_q <= '0;
            cmp_q  <= CMP_RST_VAL;
            cnt_q  <= '0;
            ovif_q <= 1'b0;
            rst_q  <= 1'b0;
        end else begin
            if (wr_ok && sel == REG_CTRL) ctrl_q <= apb.pwdata_i[2:0];
            if (wr_ok && sel == REG_PSCR) pscr_q <= apb.pwdata_i[PSC_W-1:0];
            if (wr_ok && sel == REG_CMP)  cmp_q  <= apb.pwdata_i;

            if (feed || ovf) cnt_q <= '0;
            else if (tick)   cnt_q <= cnt_q + 1'b1;

            // A new overflow outranks a simultaneous W1C.
            if (ovf)
                ovif_q <= 1'b1;
            else if (wr_ok && sel == REG_STAT && apb.pwdata_i[0])
                ovif_q <= 1'b0;

            rst_q <= ovf & ctrl_q[CTRL_RSTEN];
        end
    end

    always_comb begin
        apb.prdata_o = '0;
        if (apb.psel_i && !apb.pwrite_i) begin
            case (sel)
                REG_CTRL: apb.prdata_o = {29'b0, ctrl_q};
                REG_PSCR: apb.prdata_o = {{(32 - PSC_W){1'b0}}, pscr_q};
                REG_CNT:  apb.prdata_o = cnt_q;
                REG_CMP:  apb.prdata_o = cmp_q;
                REG_STAT: apb.prdata_o = {30'b0, locked, ovif_q};
                default:  apb.prdata_o = '0;
            endcase
        end
    end

    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = err;
    assign irq_o         = ovif_q & ctrl_q[CTRL_IRQEN];
    assign rst_o         = rst_q;
endmodule

// File: tb/tb_apb4_watchdog.sv
// Self-checking bench for apb4_watchdog. Expected counter values come from
// elapsed-cycle arithmetic: with EN held since an anchor edge where pcnt and
// CNT were both zero, after E edges CNT = floor(E/(N+1)) mod (CMP+1), and
// overflows fall on edges that are multiples of (CMP+1)*(N+1).
module tb_apb4_watchdog;
    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_PSCR = 12'h004;
    localparam logic [11:0] A_CNT  = 12'h008;
    localparam logic [11:0] A_CMP  = 12'h00C;
    localparam logic [11:0] A_STAT = 12'h010;
    localparam logic [11:0] A_KEY  = 12'h014;
    localparam logic [11:0] A_FEED = 12'h018;
    localparam logic [11:0] A_RSVD = 12'h01C;
    localparam logic [31:0] KEY_VAL = 32'h5F37_59DF;
`ifdef WDG_KEY_LOCK_EN
    localparam logic HAS_LOCK = 1'b1;
`else
    localparam logic HAS_LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    logic wrst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb4_watchdog_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    apb4_watchdog dut (
        .clk_i (clk),
        .rst_i (rst),
        .apb   (bus),
        .irq_o (irq),
        .rst_o (wrst)
    );

    function automatic int unsigned exp_cnt(input int unsigned e, input int unsigned n,
                                            input int unsigned c);
        return (e / (n + 1)) % (c + 1);
    endfunction

    task automatic bus_idle();
        bus.paddr_i = '0; bus.pprot_i = '0; bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        bus.pwrite_i = 1'b0; bus.pwdata_i = '0; bus.pstrb_i = '0;
    endtask

    // Returns the cycle count just after the committing edge.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                             output logic err, output int ccyc);
        @(posedge clk); #1;
        bus.paddr_i = a; bus.pwdata_i = d; bus.pwrite_i = 1'b1; bus.pstrb_i = 4'hF;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        #3 err = bus.pslverr_o;
        @(posedge clk); #1;
        ccyc = cyc;
        bus_idle();
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                            output logic err, output int scyc);
        @(posedge clk); #1;
        bus.paddr_i = a; bus.pwrite_i = 1'b0; bus.psel_i = 1'b1; bus.penable_i = 1'b0;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        #3 d = bus.prdata_o; err = bus.pslverr_o; scyc = cyc;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic prot_write(input logic [11:0] a, input logic [31:0] d,
                              output logic err, output int ccyc);
        logic e0;
        int   c0;
        apb_write(A_KEY, KEY_VAL, e0, c0);
        apb_write(a, d, err, ccyc);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic er; int s;
        bus_idle();
        rst = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (wrst !== 1'b0) begin errors++; $display("FAIL reset_rst_o: got %b expected 0", wrst); end
        checks++; if (bus.pready_o !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b expected 1", bus.pready_o); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        apb_read(A_CTRL, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        apb_read(A_CMP, d, er, s);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp: got %h expected ffffffff", d); end
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== {30'b0, HAS_LOCK, 1'b0}) begin errors++; $display("FAIL reset_stat: got %h expected %h", d, {30'b0, HAS_LOCK, 1'b0}); end
        apb_read(A_CNT, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", d); end
    endtask

    task automatic test_lock();
        logic [31:0] d, v; logic er; int s;
        do_reset();
        v = $urandom & 32'h7FFF_FFFF;
        apb_write(A_CMP, v, er, s);
        checks++; if (er !== HAS_LOCK) begin errors++; $display("FAIL locked_cmp_err: got %b expected %b", er, HAS_LOCK); end
        apb_read(A_CMP, d, er, s);
        checks++; if (d !== (HAS_LOCK ? 32'hFFFF_FFFF : v)) begin errors++; $display("FAIL locked_cmp_val: got %h expected %h", d, HAS_LOCK ? 32'hFFFF_FFFF : v); end
        apb_write(A_KEY, KEY_VAL ^ ($urandom | 32'h1), er, s);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL badkey_err: got %b expected 0", er); end
        apb_write(A_CMP, 32'h7, er, s);
        checks++; if (er !== HAS_LOCK) begin errors++; $display("FAIL badkey_cmp_err: got %b expected %b", er, HAS_LOCK); end
        apb_write(A_KEY, KEY_VAL, er, s);
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unlocked_stat: got %h expected 0", d); end
        apb_write(A_CMP, 32'h5, er, s);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL unlocked_cmp_err: got %b expected 0", er); end
        apb_read(A_CMP, d, er, s);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL unlocked_cmp_val: got %h expected 5", d); end
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== {30'b0, HAS_LOCK, 1'b0}) begin errors++; $display("FAIL relock_stat: got %h expected %h", d, {30'b0, HAS_LOCK, 1'b0}); end
        apb_read(A_KEY, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL key_read: got %h expected 0", d); end
    endtask

    task automatic test_overflow(input int unsigned n, input int unsigned c);
        logic [31:0] d; logic er; int s, anchor, e;
        int unsigned p;
        do_reset();
        prot_write(A_PSCR, n, er, s);
        prot_write(A_CMP, c, er, s);
        prot_write(A_CTRL, 32'h7, er, anchor);
        p = (c + 1) * (n + 1);
        apb_read(A_CNT, d, er, s);
        e = s - anchor;
        checks++; if (d !== exp_cnt(e, n, c)) begin errors++; $display("FAIL ovf_cnt_early n=%0d c=%0d e=%0d: got %0d expected %0d", n, c, e, d, exp_cnt(e, n, c)); end
        for (int i = 0; i < int'(p) + 4; i++) begin
            @(negedge clk);
            e = cyc - anchor;
            checks++;
            if (wrst !== (e > 0 && (e % p) == 0)) begin errors++; $display("FAIL ovf_rst_o e=%0d: got %b expected %b", e, wrst, (e > 0 && (e % p) == 0)); end
            checks++;
            if (irq !== (e >= int'(p))) begin errors++; $display("FAIL ovf_irq e=%0d: got %b expected %b", e, irq, (e >= int'(p))); end
        end
        apb_read(A_CNT, d, er, s);
        e = s - anchor;
        checks++; if (d !== exp_cnt(e, n, c)) begin errors++; $display("FAIL ovf_cnt_late e=%0d: got %0d expected %0d", e, d, exp_cnt(e, n, c)); end
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== {30'b0, HAS_LOCK, 1'b1}) begin errors++; $display("FAIL ovf_stat: got %h expected %h", d, {30'b0, HAS_LOCK, 1'b1}); end
    endtask

    task automatic test_periodic_feed();
        logic [31:0] d; logic er; int s, f;
        do_reset();
        prot_write(A_CMP, 32'd20, er, s);
        prot_write(A_CTRL, 32'h1, er, s);
        for (int i = 0; i < 6; i++) begin
            prot_write(A_FEED, $urandom, er, f);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            apb_read(A_CNT, d, er, s);
            checks++; if (d !== 32'(s - f)) begin errors++; $display("FAIL feed_cnt iter=%0d: got %0d expected %0d", i, d, s - f); end
        end
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== {30'b0, HAS_LOCK, 1'b0}) begin errors++; $display("FAIL feed_stat: got %h expected %h", d, {30'b0, HAS_LOCK, 1'b0}); end
    endtask

    task automatic test_feed_vs_overflow();
        logic [31:0] d; logic er; int s, a, cc, cc2;
        int unsigned c;
        do_reset();
        c = $urandom_range(6, 12);
        prot_write(A_CMP, c, er, s);
        prot_write(A_CTRL, 32'h7, er, a);
        apb_write(A_KEY, KEY_VAL, er, s);
        wait_until(a + int'(c) + 1 - 3);
        apb_write(A_FEED, 32'h0, er, cc);
        if (cc != a + int'(c) + 1) begin
            $display("FAIL feed_align: commit %0d required %0d", cc, a + int'(c) + 1);
            $fatal(1, "feed alignment lost");
        end
        #3;
        checks++; if (wrst !== 1'b0) begin errors++; $display("FAIL feedwin_rst_o: got %b expected 0", wrst); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL feedwin_irq: got %b expected 0", irq); end
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== {30'b0, HAS_LOCK, 1'b0}) begin errors++; $display("FAIL feedwin_stat: got %h expected %h", d, {30'b0, HAS_LOCK, 1'b0}); end
        apb_read(A_CNT, d, er, s);
        checks++; if (d !== exp_cnt(s - cc, 0, c)) begin errors++; $display("FAIL feedwin_cnt: got %0d expected %0d", d, exp_cnt(s - cc, 0, c)); end
        wait_until(cc + int'(c) + 2);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL post_feed_ovf_irq: got %b expected 1", irq); end
        apb_write(A_STAT, 32'h1, er, s);
        #3;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
        wait_until(cc + 2 * (int'(c) + 1) - 3);
        apb_write(A_STAT, 32'h1, er, cc2);
        if (cc2 != cc + 2 * (int'(c) + 1)) begin
            $display("FAIL w1c_align: commit %0d required %0d", cc2, cc + 2 * (int'(c) + 1));
            $fatal(1, "w1c alignment lost");
        end
        #3;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_vs_ovf_irq: got %b expected 1", irq); end
        checks++; if (wrst !== 1'b1) begin errors++; $display("FAIL w1c_vs_ovf_rst_o: got %b expected 1", wrst); end
    endtask

    task automatic test_errors();
        logic [31:0] d, v, ctrl_exp; logic er; int s;
        do_reset();
        ctrl_exp = 32'h0;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            prot_write(A_CTRL, v & 32'hFFFF_FFFE, er, s);
            ctrl_exp = v & 32'h6;
            apb_read(A_CTRL, d, er, s);
            checks++; if (d !== ctrl_exp) begin errors++; $display("FAIL ctrl_rw: got %h expected %h", d, ctrl_exp); end
            prot_write(A_PSCR, v, er, s);
            apb_read(A_PSCR, d, er, s);
            checks++; if (d !== (v & 32'h000F_FFFF)) begin errors++; $display("FAIL pscr_rw: got %h expected %h", d, v & 32'h000F_FFFF); end
        end
        apb_read(A_RSVD, d, er, s);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rsvd_read_err: got %b expected 1", er); end
        apb_write(A_KEY, KEY_VAL, er, s);
        apb_write(A_RSVD, $urandom, er, s);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rsvd_write_err: got %b expected 1", er); end
        apb_write(A_CNT, $urandom | 32'h1, er, s);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL cnt_write_err: got %b expected 1", er); end
        apb_read(A_CNT, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cnt_after_write: got %h expected 0", d); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL cnt_read_err: got %b expected 0", er); end
        apb_read(A_CTRL, d, er, s);
        checks++; if (d !== ctrl_exp) begin errors++; $display("FAIL ctrl_after_err: got %h expected %h", d, ctrl_exp); end
        apb_read(A_STAT, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL stat_still_unlocked: got %h expected 0", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic er; int s;
        do_reset();
        prot_write(A_CMP, 32'h2, er, s);
        prot_write(A_CTRL, 32'h7, er, s);
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
        #2 rst = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
        checks++; if (wrst !== 1'b0) begin errors++; $display("FAIL async_reset_rst_o: got %b expected 0", wrst); end
        @(posedge clk); #1 rst = 1'b0;
        apb_read(A_CMP, d, er, s);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_reset_cmp: got %h expected ffffffff", d); end
        apb_read(A_CNT, d, er, s);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_reset_cnt: got %h expected 0", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus_idle();
        test_reset();
        test_lock();
        test_overflow(3, 5);
        test_overflow($urandom_range(0, 3), $urandom_range(1, 5));
        test_periodic_feed();
        test_feed_vs_overflow();
        test_errors();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
